// File: rtl/predict_pkg.sv
// Shared defaults and FSM state encoding for the dot-product accumulator
// and its requantiser.
package predict_pkg;

    localparam int PROD_WIDTH_DEF = 47;
    localparam int ACC_WIDTH_DEF  = 56;
    localparam int OUT_WIDTH_DEF  = 16;
    localparam int FRAC_SHIFT_DEF = 15;
    localparam int MAX_TERMS_DEF  = 256;
    localparam int BIAS_WIDTH     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/predict_requant.sv
// Combinational requantiser: round-half-up arithmetic shift, optional ReLU,
// and signed saturation to OUT_WIDTH.
module predict_requant
    import predict_pkg::*;
#(
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
    parameter int RELU_EN    = 1
) (
    input  logic signed [ACC_WIDTH-1:0] i_acc,
    output logic signed [OUT_WIDTH-1:0] o_data,
    output logic                        o_sat
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int RW = ACC_WIDTH + 1;
    localparam logic signed [RW-1:0] HALF = RW'(1) << (FRAC_SHIFT - 1);

    logic signed [RW-1:0] w_r;
    logic                 w_pos_ovf;
    logic                 w_neg_ovf;

    assign w_r = (signed'({i_acc[ACC_WIDTH-1], i_acc}) + HALF) >>> FRAC_SHIFT;

    // Out of range when the bits above the output sign bit are not a pure sign extension.
    assign w_pos_ovf = !w_r[RW-1] && (|w_r[RW-2:OUT_WIDTH-1]);
    assign w_neg_ovf =  w_r[RW-1] && !(&w_r[RW-2:OUT_WIDTH-1]);

    always_comb begin
        o_data = w_r[OUT_WIDTH-1:0];
        o_sat  = 1'b0;
        if ((RELU_EN != 0) && w_r[RW-1]) begin
            o_data = '0;
        end else if (w_pos_ovf) begin
            o_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            o_sat  = 1'b1;
        end else if (w_neg_ovf) begin
            o_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            o_sat  = 1'b1;
        end
    end

endmodule

// File: rtl/predict_dot_accum.sv
// Streaming dot-product accumulator: bias plus up to MAX_TERMS products,
// requantised to a signed activation held until the consumer takes it.
module predict_dot_accum
    import predict_pkg::*;
#(
    parameter int PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
    parameter int MAX_TERMS  = MAX_TERMS_DEF,
    parameter int RELU_EN    = 1
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic signed [PROD_WIDTH-1:0] prod_data,
    input  logic                         prod_valid,
    input  logic                         prod_last,
    output logic                         prod_ready,
    input  logic signed [BIAS_WIDTH-1:0] bias_data,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sat,
    output logic                         out_ovr,
    output state_t                       o_dbg_state
);

    localparam int CW = $clog2(MAX_TERMS + 1);

    // Handshakes: a beat transfers on a rising edge where valid and ready
    // are both high; the producer holds data stable while valid waits on ready.
    state_t                      r_state;
    state_t                      w_state_next;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] w_acc_next;
    logic signed [ACC_WIDTH-1:0] w_acc_base;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] w_bias_ext;
    logic [CW-1:0]               r_count;
    logic [CW-1:0]               w_count_next;
    logic [CW-1:0]               w_count_inc;
    logic                        w_accept;
    logic                        w_final;
    logic                        w_ovr_next;
    logic signed [OUT_WIDTH-1:0] w_rq_data;
    logic                        w_rq_sat;
    logic signed [OUT_WIDTH-1:0] r_out_data;
    logic                        r_out_sat;
    logic                        r_out_ovr;

    assign w_prod_ext  = {{(ACC_WIDTH-PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
    assign w_bias_ext  = {{(ACC_WIDTH-BIAS_WIDTH){bias_data[BIAS_WIDTH-1]}}, bias_data};
    assign prod_ready  = (r_state != OUT);
    assign w_accept    = prod_valid && prod_ready;
    // The first beat of a vector seeds from the bias instead of the running sum.
    assign w_acc_base  = (r_state == IDLE) ? w_bias_ext : r_acc;
    assign w_count_inc = (r_state == IDLE) ? CW'(1) : r_count + CW'(1);

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_count_next = r_count;
        w_final      = 1'b0;
        w_ovr_next   = 1'b0;
        case (r_state)
            IDLE, ACC: begin
                if (w_accept) begin
                    w_acc_next   = w_acc_base + w_prod_ext;
                    w_count_next = w_count_inc;
                    if (prod_last || (w_count_inc == CW'(MAX_TERMS))) begin
                        w_final      = 1'b1;
                        w_ovr_next   = !prod_last;
                        w_state_next = OUT;
                    end else begin
                        w_state_next = ACC;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                    w_count_next = '0;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    predict_requant #(
        .ACC_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .FRAC_SHIFT (FRAC_SHIFT),
        .RELU_EN    (RELU_EN)
    ) u_requant (
        .i_acc  (w_acc_next),
        .o_data (w_rq_data),
        .o_sat  (w_rq_sat)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_count    <= '0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
            r_out_ovr  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_count <= w_count_next;
            if (w_final) begin
                r_out_data <= w_rq_data;
                r_out_sat  <= w_rq_sat;
                r_out_ovr  <= w_ovr_next;
            end
        end
    end

    assign out_valid   = (r_state == OUT);
    assign out_data    = r_out_data;
    assign out_sat     = r_out_sat;
    assign out_ovr     = r_out_ovr;
    assign o_dbg_state = r_state;

endmodule

// File: doc/predict_dot_accum.md
PREDICT_DOT_ACCUM -- requirements
Module: predict_dot_accum

Interface
REQ-001 SHALL have parameter PROD_WIDTH, default 47, signed product width from the upstream 31x16 multiplier.
REQ-002 SHALL have parameter ACC_WIDTH, default 56, signed accumulator width.
REQ-003 SHALL have parameter OUT_WIDTH, default 16, signed activation output width.
REQ-004 SHALL have parameter FRAC_SHIFT, default 15, requantisation right-shift amount (>=1).
REQ-005 SHALL have parameter MAX_TERMS, default 256, maximum number of products per dot product.
REQ-006 SHALL have parameter RELU_EN, default 1, enabling ReLU on the output.
REQ-007 SHALL have port ap_clk  in  1  the single clock; all state on its rising edge.
REQ-008 SHALL have port ap_rst  in  1  reset, asynchronous, active-high.
REQ-009 SHALL have port prod_data  in  PROD_WIDTH  signed product term.
REQ-010 SHALL have port prod_valid  in  1  product beat valid.
REQ-011 SHALL have port prod_last  in  1  marks the final term of the current dot product.
REQ-012 SHALL have port prod_ready  out  1  block accepts a product beat.
REQ-013 SHALL have port bias_data  in  32  signed bias, sampled on the first beat of each vector.
REQ-014 SHALL have port out_data  out  OUT_WIDTH  signed requantised activation.
REQ-015 SHALL have port out_valid  out  1  out_data valid.
REQ-016 SHALL have port out_ready  in  1  downstream accepts out_data.
REQ-017 SHALL have port out_sat  out  1  saturation occurred for the presented out_data.
REQ-018 SHALL have port out_ovr  out  1  the vector was truncated at MAX_TERMS.

Function
REQ-019 SHALL implement FSM states IDLE, ACC, OUT; a beat is accepted when prod_valid and prod_ready are both high.
REQ-020 SHALL drive prod_ready high in IDLE and ACC and low in OUT.
REQ-021 IDLE accept: acc <= sext(bias_data) + sext(prod_data), term count <= 1; next state ACC, or OUT if prod_last.
REQ-022 ACC accept: acc <= acc + sext(prod_data), count += 1; next state OUT on prod_last or when count reaches MAX_TERMS.
REQ-023 A vector forced to end at MAX_TERMS without prod_last SHALL set out_ovr with that output; the next beat starts a new vector.
REQ-024 Requantisation SHALL compute r = (final_acc + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT (arithmetic shift, round half up).
REQ-025 With RELU_EN=1, negative r SHALL yield 0 with out_sat=0.
REQ-026 r outside the signed OUT_WIDTH range SHALL clamp to the max/min value with out_sat=1.
REQ-027 out_data, out_sat and out_ovr SHALL be registered on the final-beat edge; out_valid SHALL rise on the first cycle after the final beat is accepted (latency 1).
REQ-028 In OUT, out_data, out_sat, out_ovr and out_valid SHALL hold stable until out_ready is high, then return to IDLE with out_valid=0 on the next cycle.
REQ-029 Throughput SHALL be one vector per N+1 cycles minimum; no product beats SHALL be accepted while in OUT.
REQ-030 Accumulator arithmetic SHALL use full ACC_WIDTH with no internal overflow for MAX_TERMS full-scale terms plus bias.

Reset
REQ-031 ap_rst high SHALL immediately force: state IDLE, acc 0, count 0, out_data 0, out_valid 0, out_sat 0, out_ovr 0; prod_ready SHALL be 1 after release.
REQ-032 Reset mid-vector or mid-OUT SHALL discard the partial result; no output SHALL be produced for it.

Structure
REQ-033 The shared package predict_pkg SHALL hold the width defaults, FRAC_SHIFT, MAX_TERMS and the FSM state enum.
REQ-034 Shift, round, ReLU and saturation SHALL reside in one combinational sub-module, predict_requant; the FSM, counter and accumulator SHALL remain in the top level.

Verification (FRAC_SHIFT=15, RELU_EN=1 unless stated)
REQ-035 Basic: bias 0, products 32768, 65536 (last) -> out_data 3, out_sat 0, out_valid one cycle after the last beat.
REQ-036 Rounding: single product 16384 -> 1; 16383 -> 0; RELU_EN=0, -16385 -> -1.
REQ-037 Saturation/ReLU: product 2^40 -> 32767 with out_sat 1; product -65536 -> 0 with out_sat 0.
REQ-038 Backpressure: out_ready low 5 cycles -> out_valid and out_data held, prod_ready 0 throughout; handshake on cycle 6 -> IDLE.
REQ-039 Overrun: 257 beats of 32768 with no last -> output after beat 256 = 256 with out_ovr 1; beat 257 starts a new vector.
REQ-040 Reset: assert ap_rst after 3 beats -> all outputs 0 at once; a new 1-beat vector of 32768 -> out_data 1.
